egress_port_tx: RTL and testbench

Egress transmitter for one switch output port; the read-side counterpart of the per-port priority queue. It pops the earliest-deadline packet descriptor, streams the stored bytes out of the queue's data RAM in one contiguous burst, and re-frames them onto the port's byte stream (`tx_sof`/`tx_dv`/`tx_data`) with an enforced inter-frame gap. It sits between the priority queue's read interface and the output PHY/MAC shim.

---
 rtl/egress_port_tx.sv | 180 ++++++++++++++++++
 tb/tb_egress_port_tx.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_port_tx.sv
// egress_port_tx: read side of a per-port priority queue.
// Pops one descriptor, streams its L stored bytes out of the data RAM in a
// single contiguous burst, and re-frames them as tx_sof/tx_dv/tx_data.
// After the frame it holds an inter-frame gap before the next pop.
// Optional feature: define EGRESS_TX_HDR_EN to prepend a two-byte header
// {(L+2)[11:8], PORT_MASK}, (L+2)[7:0] to every frame.
module egress_port_tx #(
  parameter int         IFG_CYCLES = 12,
  parameter logic [3:0] PORT_MASK  = 4'b0001,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tx_bp,
  input  logic                 ptr_fifo_empty,
  output logic                 ptr_fifo_rd,
  input  logic                 packet_rd_valid,
  input  logic [15:0]          ptr_fifo_dout,
  output logic                 data_fifo_rd,
  input  logic [7:0]           data_fifo_dout,
  output logic                 tx_sof,
  output logic                 tx_dv,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] tx_pkt_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  localparam int DATA_W = 8;
  localparam int LEN_W  = 12;

`ifdef EGRESS_TX_HDR_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_POP   = 4'd1;
  localparam logic [3:0] S_WAIT  = 4'd2;
  localparam logic [3:0] S_LOAD  = 4'd3;
  localparam logic [3:0] S_HDR0  = 4'd4;
  localparam logic [3:0] S_HDR1  = 4'd5;
  localparam logic [3:0] S_READ  = 4'd6;
  localparam logic [3:0] S_FLUSH = 4'd7;
  localparam logic [3:0] S_GAP   = 4'd8;

  // GAP lasts IFG_CYCLES cycles starting on the cycle the last byte is on the wire.
  localparam logic [7:0] GAP_LAST = 8'(IFG_CYCLES - 1);

  logic [3:0]        state;
  logic [3:0]        nxt;
  logic [LEN_W-1:0]  pkt_len;
  logic [LEN_W-1:0]  rd_cnt;
  logic [7:0]        gap_cnt;
  logic              load_zero;
  logic              vld_p0;
  logic              sof_p0;
  logic              unused_desc_bits;

  // Frame length with header: L+2 kept 13 bits, header uses the low 12 (wraps above 4093).
  function automatic logic [12:0] hdr_len(input logic [LEN_W-1:0] len);
    return {1'b0, len} + 13'd2;
  endfunction

  function automatic logic [DATA_W-1:0] hdr_byte0(input logic [LEN_W-1:0] len);
    logic [12:0] s;
    s = hdr_len(len);
    return {s[11:8], PORT_MASK};
  endfunction

  function automatic logic [DATA_W-1:0] hdr_byte1(input logic [LEN_W-1:0] len);
    logic [12:0] s;
    s = hdr_len(len);
    return s[7:0];
  endfunction

  assign unused_desc_bits = ^ptr_fifo_dout[15:12];

  // Descriptor is valid on ptr_fifo_dout throughout LOAD.
  assign load_zero = (ptr_fifo_dout[LEN_W-1:0] == '0);

  // Control outputs decoded from state so an async reset clears them at once.
  assign ptr_fifo_rd  = (state == S_POP);
  assign data_fifo_rd = ((state == S_LOAD) && load_zero) || (state == S_HDR1) || (state == S_READ);
  assign busy         = (state != S_IDLE);

  // Next-state logic; tx_bp only gates the IDLE->POP decision.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (!ptr_fifo_empty && !tx_bp) nxt = S_POP;
      S_POP:   nxt = S_WAIT;
      S_WAIT:  if (packet_rd_valid) nxt = S_LOAD;
      S_LOAD: begin
        if (load_zero)   nxt = S_GAP;
        else if (HDR_EN) nxt = S_HDR0;
        else             nxt = S_READ;
      end
      S_HDR0:  nxt = S_HDR1;
      S_HDR1:  nxt = (pkt_len == 12'd1) ? S_FLUSH : S_READ;
      S_READ:  if (rd_cnt + 12'd1 == pkt_len) nxt = S_FLUSH;
      S_FLUSH: nxt = S_GAP;
      S_GAP:   if (gap_cnt == GAP_LAST) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // FSM state, read counter and gap counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      rd_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      state <= nxt;
      if (state == S_LOAD)
        rd_cnt <= '0;
      else if (data_fifo_rd)
        rd_cnt <= rd_cnt + 12'd1;
      if (state == S_GAP)
        gap_cnt <= gap_cnt + 8'd1;
      else
        gap_cnt <= '0;
    end
  end

  // Packet length captured from the descriptor in LOAD.
  always_ff @(posedge clk) begin
    if (state == S_LOAD)
      pkt_len <= ptr_fifo_dout[LEN_W-1:0];
  end

  // ---- stage p0: RAM read data is valid on data_fifo_dout ----
  // The dummy read of a zero-length descriptor never produces a byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p0 <= 1'b0;
      sof_p0 <= 1'b0;
    end else begin
      vld_p0 <= data_fifo_rd && (state != S_LOAD);
      sof_p0 <= data_fifo_rd && (state == S_READ) && (rd_cnt == '0) && !HDR_EN;
    end
  end

  // ---- stage p1: registered byte stream; header bytes injected ahead of payload ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_dv   <= 1'b0;
      tx_sof  <= 1'b0;
      tx_data <= '0;
    end else if (state == S_HDR0) begin
      tx_dv   <= 1'b1;
      tx_sof  <= 1'b1;
      tx_data <= hdr_byte0(pkt_len);
    end else if (state == S_HDR1) begin
      tx_dv   <= 1'b1;
      tx_sof  <= 1'b0;
      tx_data <= hdr_byte1(pkt_len);
    end else begin
      tx_dv   <= vld_p0;
      tx_sof  <= sof_p0;
      tx_data <= vld_p0 ? data_fifo_dout : '0;
    end
  end

  // Frame and drop counters, both free-running with wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_pkt_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (state == S_FLUSH)
        tx_pkt_cnt <= tx_pkt_cnt + 1'b1;
      if ((state == S_LOAD) && load_zero)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_egress_port_tx.sv
// Testbench for egress_port_tx: behavioural priority-queue model on the read
// side, scoreboard of expected tx bytes, and per-scenario checks.
module tb_egress_port_tx;

  localparam int         IFG       = 12;
  localparam logic [3:0] PMASK     = 4'b0001;
  localparam int         CW        = 16;
`ifdef EGRESS_TX_HDR_EN
  localparam int HL = 2;
`else
  localparam int HL = 0;
`endif

  typedef struct packed {
    logic       sof;
    logic [7:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          tx_bp;
  logic          ptr_fifo_empty = 1'b1;
  logic          ptr_fifo_rd;
  logic          packet_rd_valid;
  logic [15:0]   ptr_fifo_dout;
  logic          data_fifo_rd;
  logic [7:0]    data_fifo_dout;
  logic          tx_sof;
  logic          tx_dv;
  logic [7:0]    tx_data;
  logic          busy;
  logic [CW-1:0] tx_pkt_cnt;
  logic [CW-1:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  // queue model state
  logic [11:0] len_q[$];
  logic [7:0]  mem_q[$];
  logic [11:0] cur_desc;
  int          cur_rem;
  logic [1:0]  pend;

  // scoreboard and monitor state
  exp_t exp_q[$];
  exp_t mon_e;
  int   dvrun_q[$];
  int   rdrun_q[$];
  int   sofgap_q[$];
  int   sofrd_q[$];
  int   cyc = 0;
  int   dv_run = 0;
  int   rd_run = 0;
  int   rd_rise_cyc = 0;
  int   last_dv_cyc = -1000;
  int   pops = 0;

  egress_port_tx #(
    .IFG_CYCLES(IFG),
    .PORT_MASK (PMASK),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .tx_bp          (tx_bp),
    .ptr_fifo_empty (ptr_fifo_empty),
    .ptr_fifo_rd    (ptr_fifo_rd),
    .packet_rd_valid(packet_rd_valid),
    .ptr_fifo_dout  (ptr_fifo_dout),
    .data_fifo_rd   (data_fifo_rd),
    .data_fifo_dout (data_fifo_dout),
    .tx_sof         (tx_sof),
    .tx_dv          (tx_dv),
    .tx_data        (tx_data),
    .busy           (busy),
    .tx_pkt_cnt     (tx_pkt_cnt),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Queue read side: descriptor arrives two cycles after the pop, the data RAM
  // answers one cycle after each read; reads past the descriptor return 0xEE.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend            <= 2'd0;
      packet_rd_valid <= 1'b0;
      ptr_fifo_dout   <= 16'h0;
      data_fifo_dout  <= 8'h0;
      cur_rem         <= 0;
      cur_desc        <= 12'h0;
    end else begin
      if (ptr_fifo_rd && len_q.size() > 0) begin
        cur_desc <= len_q.pop_front();
        pend     <= 2'd2;
      end else if (pend == 2'd2) begin
        packet_rd_valid <= 1'b1;
        pend            <= 2'd1;
      end else if (pend == 2'd1) begin
        packet_rd_valid <= 1'b0;
        ptr_fifo_dout   <= {4'h0, cur_desc};
        cur_rem         <= int'(cur_desc);
        pend            <= 2'd0;
      end
      if (data_fifo_rd) begin
        if (cur_rem > 0 && mem_q.size() > 0) begin
          data_fifo_dout <= mem_q.pop_front();
          cur_rem        <= cur_rem - 1;
        end else begin
          data_fifo_dout <= 8'hEE;
        end
      end
    end
  end

  // Monitor: scoreboard compare on every tx byte, plus run/gap bookkeeping.
  initial begin
    forever begin
      @(negedge clk);
      ptr_fifo_empty = (len_q.size() == 0);
      if (!rstn) begin
        dv_run = 0;
        rd_run = 0;
      end else begin
        if (ptr_fifo_rd) pops++;
        if (data_fifo_rd) begin
          if (rd_run == 0) rd_rise_cyc = cyc;
          rd_run++;
        end else if (rd_run > 0) begin
          rdrun_q.push_back(rd_run);
          rd_run = 0;
        end
        if (tx_dv) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL tx_byte unexpected: got sof=%0b data=%02h, required no byte", tx_sof, tx_data);
          end else begin
            mon_e = exp_q.pop_front();
            if (tx_sof !== mon_e.sof || tx_data !== mon_e.data) begin
              failures++;
              $display("FAIL tx_byte: got sof=%0b data=%02h, required sof=%0b data=%02h",
                       tx_sof, tx_data, mon_e.sof, mon_e.data);
            end
          end
          if (tx_sof) begin
            sofgap_q.push_back(cyc - last_dv_cyc - 1);
            sofrd_q.push_back(cyc - rd_rise_cyc);
            dv_run = 1;
          end else begin
            dv_run++;
          end
          last_dv_cyc = cyc;
        end else if (dv_run > 0) begin
          dvrun_q.push_back(dv_run);
          dv_run = 0;
        end
      end
    end
  end

  // Queue a packet of len bytes base, base+1, ... and its expected tx bytes.
  task automatic enqueue(input int len, input logic [7:0] base);
    logic [12:0] sum;
    exp_t        e;
    sum = 13'(len) + 13'd2;
    for (int i = 0; i < len; i++) mem_q.push_back(8'(int'(base) + i));
    if (len > 0) begin
`ifdef EGRESS_TX_HDR_EN
      e.sof = 1'b1; e.data = {sum[11:8], PMASK}; exp_q.push_back(e);
      e.sof = 1'b0; e.data = sum[7:0];           exp_q.push_back(e);
      for (int i = 0; i < len; i++) begin
        e.sof = 1'b0; e.data = 8'(int'(base) + i); exp_q.push_back(e);
      end
`else
      for (int i = 0; i < len; i++) begin
        e.sof = (i == 0); e.data = 8'(int'(base) + i); exp_q.push_back(e);
      end
`endif
    end
    len_q.push_back(12'(len));
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (len_q.size() == 0 && !busy && !tx_dv && pend == 2'd0) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    dvrun_q.delete();
    rdrun_q.delete();
    sofgap_q.delete();
    sofrd_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({tx_dv, tx_sof, ptr_fifo_rd, data_fifo_rd, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got dv/sof/prd/drd/busy=%05b, required 00000",
               {tx_dv, tx_sof, ptr_fifo_rd, data_fifo_rd, busy});
    end
    checks++;
    if (tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got %02h, required 00", tx_data);
    end
    checks++;
    if (tx_pkt_cnt !== '0 || drop_cnt !== '0) begin
      failures++;
      $display("FAIL reset_cnt: got pkt=%0d drop=%0d, required 0 0", tx_pkt_cnt, drop_cnt);
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || ptr_fifo_rd !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%0b pop=%0b with empty queue, required 0 0", busy, ptr_fifo_rd);
    end
  endtask

  task automatic test_single();
    bit ok;
    int v;
    clear_logs();
    enqueue(5, 8'h11);
    wait_quiet(400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout: got busy=%0b, required idle", busy); end
    checks++;
    if (tx_pkt_cnt !== 16'd1) begin failures++; $display("FAIL single_pkt_cnt: got %0d, required 1", tx_pkt_cnt); end
    v = -1; if (dvrun_q.size() > 0) v = dvrun_q.pop_front();
    checks++;
    if (v != 5 + HL) begin failures++; $display("FAIL single_frame_len: got %0d, required %0d", v, 5 + HL); end
    v = -1; if (rdrun_q.size() > 0) v = rdrun_q.pop_front();
    checks++;
    if (v != 5) begin failures++; $display("FAIL single_rd_run: got %0d, required 5", v); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int v;
    clear_logs();
    enqueue(64, 8'h40);
    enqueue(3, 8'hC0);
    wait_quiet(800, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_timeout: got busy=%0b, required idle", busy); end
    v = -1; if (rdrun_q.size() > 0) v = rdrun_q.pop_front();
    checks++;
    if (v != 64) begin failures++; $display("FAIL b2b_rd_run0: got %0d, required 64", v); end
    v = -1; if (rdrun_q.size() > 0) v = rdrun_q.pop_front();
    checks++;
    if (v != 3) begin failures++; $display("FAIL b2b_rd_run1: got %0d, required 3", v); end
    v = -1; if (dvrun_q.size() > 0) v = dvrun_q.pop_front();
    checks++;
    if (v != 64 + HL) begin failures++; $display("FAIL b2b_frame0_len: got %0d, required %0d", v, 64 + HL); end
    v = -1; if (dvrun_q.size() > 0) v = dvrun_q.pop_front();
    checks++;
    if (v != 3 + HL) begin failures++; $display("FAIL b2b_frame1_len: got %0d, required %0d", v, 3 + HL); end
    if (sofgap_q.size() > 0) v = sofgap_q.pop_front();
    v = -1; if (sofgap_q.size() > 0) v = sofgap_q.pop_front();
    checks++;
    if (v < IFG) begin failures++; $display("FAIL b2b_ifg: got %0d idle cycles, required >= %0d", v, IFG); end
    checks++;
    if (tx_pkt_cnt !== 16'd3) begin failures++; $display("FAIL b2b_pkt_cnt: got %0d, required 3", tx_pkt_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    int v;
    int p0;
    clear_logs();
    enqueue(100, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (tx_sof) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL bp_sof_timeout: got no tx_sof, required frame start"); end
    repeat (10) @(negedge clk);
    #1;
    tx_bp = 1'b1;
    p0 = pops;
    enqueue(4, 8'h80);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (!busy) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL bp_idle_timeout: got busy=1, required idle after frame"); end
    repeat (30) @(negedge clk);
    #1;
    checks++;
    if (pops != p0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold: got pops=%0d busy=%0b, required pops=%0d busy=0", pops, busy, p0);
    end
    v = -1; if (dvrun_q.size() > 0) v = dvrun_q.pop_front();
    checks++;
    if (v != 100 + HL) begin failures++; $display("FAIL bp_frame_len: got %0d, required %0d", v, 100 + HL); end
    tx_bp = 1'b0;
    wait_quiet(400, ok);
    checks++;
    if (!ok || pops != p0 + 1) begin
      failures++;
      $display("FAIL bp_release: got ok=%0b pops=%0d, required 1 %0d", ok, pops, p0 + 1);
    end
    checks++;
    if (tx_pkt_cnt !== 16'd5) begin failures++; $display("FAIL bp_pkt_cnt: got %0d, required 5", tx_pkt_cnt); end
  endtask

  task automatic test_zero_len();
    bit ok;
    int v;
    clear_logs();
    enqueue(0, 8'h00);
    enqueue(2, 8'h5A);
    wait_quiet(400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL zero_timeout: got busy=%0b, required idle", busy); end
    v = -1; if (rdrun_q.size() > 0) v = rdrun_q.pop_front();
    checks++;
    if (v != 1) begin failures++; $display("FAIL zero_dummy_rd: got %0d, required 1", v); end
    v = -1; if (rdrun_q.size() > 0) v = rdrun_q.pop_front();
    checks++;
    if (v != 2) begin failures++; $display("FAIL zero_next_rd: got %0d, required 2", v); end
    checks++;
    if (dvrun_q.size() != 1) begin failures++; $display("FAIL zero_frames: got %0d, required 1", dvrun_q.size()); end
    v = -1; if (dvrun_q.size() > 0) v = dvrun_q.pop_front();
    checks++;
    if (v != 2 + HL) begin failures++; $display("FAIL zero_next_len: got %0d, required %0d", v, 2 + HL); end
    checks++;
    if (drop_cnt !== 16'd1 || tx_pkt_cnt !== 16'd6) begin
      failures++;
      $display("FAIL zero_counts: got drop=%0d pkt=%0d, required 1 6", drop_cnt, tx_pkt_cnt);
    end
  endtask

  task automatic test_midframe_reset();
    bit seen;
    clear_logs();
    enqueue(64, 8'h20);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (dv_run == 20) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rst_mid_timeout: got %0d bytes, required 20", dv_run); end
    rstn = 1'b0;
    #1;
    checks++;
    if ({tx_dv, tx_sof, data_fifo_rd, ptr_fifo_rd, busy} !== 5'b0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_outputs: got dv/sof/drd/prd/busy=%05b data=%02h, required 00000 00",
               {tx_dv, tx_sof, data_fifo_rd, ptr_fifo_rd, busy}, tx_data);
    end
    len_q.delete();
    mem_q.delete();
    exp_q.delete();
    @(negedge clk); #1;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || tx_dv !== 1'b0 || tx_pkt_cnt !== '0 || drop_cnt !== '0) begin
      failures++;
      $display("FAIL rst_mid_after: got busy=%0b dv=%0b pkt=%0d drop=%0d, required 0 0 0 0",
               busy, tx_dv, tx_pkt_cnt, drop_cnt);
    end
  endtask

  task automatic test_single_byte();
    bit ok;
    int v;
    clear_logs();
    enqueue(1, 8'hA5);
    wait_quiet(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL l1_timeout: got busy=%0b, required idle", busy); end
    v = -1; if (sofrd_q.size() > 0) v = sofrd_q.pop_front();
    checks++;
    if (v != 2 - HL) begin failures++; $display("FAIL l1_sof_latency: got %0d, required %0d", v, 2 - HL); end
    v = -1; if (dvrun_q.size() > 0) v = dvrun_q.pop_front();
    checks++;
    if (v != 1 + HL) begin failures++; $display("FAIL l1_frame_len: got %0d, required %0d", v, 1 + HL); end
    v = -1; if (rdrun_q.size() > 0) v = rdrun_q.pop_front();
    checks++;
    if (v != 1) begin failures++; $display("FAIL l1_rd_run: got %0d, required 1", v); end
    checks++;
    if (tx_pkt_cnt !== 16'd1) begin failures++; $display("FAIL l1_pkt_cnt: got %0d, required 1", tx_pkt_cnt); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn  = 1'b0;
    tx_bp = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_zero_len();
    test_midframe_reset();
    test_single_byte();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d bytes outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
